// File: rtl/led_pattern_pkg.sv
// Shared constants for the LED pattern generator: channel mode encodings and
// config field widths.
package led_pattern_pkg;

  localparam int CFG_MODE_W = 3;
  localparam int CFG_CHAN_W = 4;

  localparam logic [CFG_MODE_W-1:0] MODE_OFF     = 3'd0;
  localparam logic [CFG_MODE_W-1:0] MODE_ON      = 3'd1;
  localparam logic [CFG_MODE_W-1:0] MODE_BLINK   = 3'd2;
  localparam logic [CFG_MODE_W-1:0] MODE_PWM     = 3'd3;
  localparam logic [CFG_MODE_W-1:0] MODE_BREATHE = 3'd4;

endpackage

// File: rtl/led_pattern_gen_channel.sv
// One LED channel: config registers, tick counter, blink phase, optional
// breathe ramp (LED_BREATHE_EN) and the registered LED drive.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int RATE_W   = 16,
  parameter int PWM_BITS = 8
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  wr_en,
  input  logic [CFG_MODE_W-1:0] wr_mode,
  input  logic [RATE_W-1:0]     wr_rate,
  input  logic [PWM_BITS-1:0]   wr_level,
  input  logic                  tick,
  input  logic [PWM_BITS-1:0]   pwm_cnt,
  output logic                  led
);

  localparam logic [RATE_W-1:0]   CNT_ONE = RATE_W'(1'b1);
  localparam logic [PWM_BITS-1:0] LVL_ONE = PWM_BITS'(1'b1);
  localparam logic [PWM_BITS-1:0] LVL_MAX = {PWM_BITS{1'b1}};

  logic [CFG_MODE_W-1:0] mode_r;
  logic [RATE_W-1:0]     rate_r;
  logic [PWM_BITS-1:0]   level_r;
  logic [RATE_W-1:0]     cnt_r;
  logic                  phase_r;
  logic                  led_r;
  logic                  led_next_s;
  logic                  step_s;

  // A step fires on a tick where the counter has reached the programmed rate.
  assign step_s = tick && (cnt_r == rate_r);

  // Config load and tick counter; a write wins over a coincident tick.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      mode_r  <= MODE_OFF;
      rate_r  <= {RATE_W{1'b0}};
      level_r <= {PWM_BITS{1'b0}};
      cnt_r   <= {RATE_W{1'b0}};
      phase_r <= 1'b0;
    end else if (wr_en) begin
      mode_r  <= wr_mode;
      rate_r  <= wr_rate;
      level_r <= wr_level;
      cnt_r   <= {RATE_W{1'b0}};
      phase_r <= 1'b0;
    end else if (step_s) begin
      cnt_r   <= {RATE_W{1'b0}};
      phase_r <= ~phase_r;
    end else if (tick) begin
      cnt_r   <= cnt_r + CNT_ONE;
    end
  end

`ifdef LED_BREATHE_EN
  logic [PWM_BITS-1:0] breathe_lvl_r;
  logic                breathe_down_r;

  // Triangle ramp: each end value lasts one step before the direction flips.
  always_ff @(posedge clk) begin
    if (s_reset || wr_en) begin
      breathe_lvl_r  <= {PWM_BITS{1'b0}};
      breathe_down_r <= 1'b0;
    end else if (step_s) begin
      if (!breathe_down_r && (breathe_lvl_r == LVL_MAX)) begin
        breathe_down_r <= 1'b1;
        breathe_lvl_r  <= breathe_lvl_r - LVL_ONE;
      end else if (breathe_down_r && (breathe_lvl_r == {PWM_BITS{1'b0}})) begin
        breathe_down_r <= 1'b0;
        breathe_lvl_r  <= breathe_lvl_r + LVL_ONE;
      end else if (breathe_down_r) begin
        breathe_lvl_r  <= breathe_lvl_r - LVL_ONE;
      end else begin
        breathe_lvl_r  <= breathe_lvl_r + LVL_ONE;
      end
    end
  end
`endif

  // LED value selected from the current mode; reserved modes read as OFF.
  always_comb begin
    led_next_s = 1'b0;
    case (mode_r)
      MODE_ON:      led_next_s = 1'b1;
      MODE_BLINK:   led_next_s = phase_r;
      MODE_PWM:     led_next_s = (pwm_cnt < level_r);
`ifdef LED_BREATHE_EN
      MODE_BREATHE: led_next_s = (pwm_cnt < breathe_lvl_r);
`endif
      default:      led_next_s = 1'b0;
    endcase
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      led_r <= 1'b0;
    end else begin
      led_r <= led_next_s;
    end
  end

  assign led = led_r;

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator top: prescaler, shared PWM counter,
// config handshake and channel decode. Optional BREATHE mode: LED_BREATHE_EN.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TICK_DIV    = 100_000,
  parameter int NUM_LEDS    = 4,
  parameter int RATE_W      = 16,
  parameter int PWM_BITS    = 8
) (
  input  logic                  clk,
  input  logic                  s_reset,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [CFG_CHAN_W-1:0] cfg_chan,
  input  logic [CFG_MODE_W-1:0] cfg_mode,
  input  logic [RATE_W-1:0]     cfg_rate,
  input  logic [PWM_BITS-1:0]   cfg_level,
  output logic                  tick,
  output logic [NUM_LEDS-1:0]   led_out
);

  localparam int                  PRESC_W   = $clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_ONE = PRESC_W'(1'b1);
  localparam logic [PRESC_W-1:0]  PRESC_END = PRESC_W'(TICK_DIV - 1);
  localparam logic [PRESC_W-1:0]  PRESC_PRE = PRESC_W'(TICK_DIV - 2);
  localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1'b1);
  localparam bit CFG_OK = (CLK_FREQ_HZ > 0) && (TICK_DIV >= 2) &&
                          (NUM_LEDS >= 1) && (NUM_LEDS <= 16);

  if (!CFG_OK) begin : g_invalid_parameters
  end

  logic [PRESC_W-1:0]  presc_r;
  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic                tick_r;
  logic                cfg_ready_r;

  // Timebase: tick is registered one count early so it lines up with the
  // cycle where the prescaler sits at its last value.
  always_ff @(posedge clk) begin
    if (s_reset) begin
      presc_r     <= {PRESC_W{1'b0}};
      tick_r      <= 1'b0;
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
      cfg_ready_r <= 1'b0;
    end else begin
      presc_r     <= (presc_r == PRESC_END) ? {PRESC_W{1'b0}} : (presc_r + PRESC_ONE);
      tick_r      <= (presc_r == PRESC_PRE);
      pwm_cnt_r   <= pwm_cnt_r + PWM_ONE;
      cfg_ready_r <= 1'b1;
    end
  end

  assign tick      = tick_r;
  assign cfg_ready = cfg_ready_r;

  // Writes to channel indices beyond NUM_LEDS match no channel and are dropped.
  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    logic wr_en_s;
    assign wr_en_s = cfg_valid && cfg_ready_r && (cfg_chan == CFG_CHAN_W'(i));

    led_channel #(
      .RATE_W   (RATE_W),
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk      (clk),
      .s_reset  (s_reset),
      .wr_en    (wr_en_s),
      .wr_mode  (cfg_mode),
      .wr_rate  (cfg_rate),
      .wr_level (cfg_level),
      .tick     (tick_r),
      .pwm_cnt  (pwm_cnt_r),
      .led      (led_out[i])
    );
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen: directed vector table, corner-case
// sequences and randomized writes against a cycle-level reference model.
module tb_led_pattern_gen;

  localparam int TD = 4;
  localparam int NL = 4;
  localparam int RW = 16;
  localparam int PB = 8;

  logic          clk = 1'b0;
  logic          s_reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [3:0]    cfg_chan;
  logic [2:0]    cfg_mode;
  logic [RW-1:0] cfg_rate;
  logic [PB-1:0] cfg_level;
  logic          tick;
  logic [NL-1:0] led_out;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .CLK_FREQ_HZ (100_000_000),
    .TICK_DIV    (TD),
    .NUM_LEDS    (NL),
    .RATE_W      (RW),
    .PWM_BITS    (PB)
  ) dut (
    .clk       (clk),
    .s_reset   (s_reset),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_mode  (cfg_mode),
    .cfg_rate  (cfg_rate),
    .cfg_level (cfg_level),
    .tick      (tick),
    .led_out   (led_out)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: per-channel config plus ticks elapsed since the last write.
  int m_mode [NL];
  int m_rate [NL];
  int m_level[NL];
  int m_n    [NL];
  int m_j = 0;
  logic m_ready = 1'b0;
  logic m_tick  = 1'b0;
  logic [NL-1:0] m_led = '0;

  typedef struct {
    logic [3:0] chan;
    logic [2:0] mode;
    logic [3:0] exp_led;
  } vec_t;
  vec_t vecs[9];

  function automatic int tri_lvl(int s);
    int m;
    m = s % 510;
    return (m <= 255) ? m : (510 - m);
  endfunction

  function automatic logic model_led(int ch);
    int pwm;
    int steps;
    pwm   = m_j % 256;
    steps = m_n[ch] / (m_rate[ch] + 1);
    case (m_mode[ch])
      1: return 1'b1;
      2: return ((steps % 2) == 1);
      3: return (pwm < m_level[ch]);
`ifdef LED_BREATHE_EN
      4: return (pwm < tri_lvl(steps));
`endif
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Advance one clock, update the model with the inputs that edge saw, compare.
  task automatic next_cycle();
    logic [NL-1:0] nled;
    logic ntick;
    logic nready;
    bit acc;
    @(posedge clk);
    #1;
    if (s_reset) begin
      nled = '0; ntick = 1'b0; nready = 1'b0;
    end else begin
      for (int ch = 0; ch < NL; ch++) nled[ch] = model_led(ch);
      ntick  = (((m_j + 1) % TD) == (TD - 1));
      nready = 1'b1;
    end
    acc = !s_reset && cfg_valid && m_ready;
    for (int ch = 0; ch < NL; ch++) begin
      if (s_reset) begin
        m_mode[ch] = 0; m_rate[ch] = 0; m_level[ch] = 0; m_n[ch] = 0;
      end else if (acc && (int'(cfg_chan) == ch)) begin
        m_mode[ch] = int'(cfg_mode); m_rate[ch] = int'(cfg_rate);
        m_level[ch] = int'(cfg_level); m_n[ch] = 0;
      end else if (m_tick) begin
        m_n[ch]++;
      end
    end
    m_j     = s_reset ? 0 : (m_j + 1);
    m_led   = nled;
    m_tick  = ntick;
    m_ready = nready;
    check("led_out", led_out, m_led);
    check("tick", tick, m_tick);
    check("cfg_ready", cfg_ready, m_ready);
  endtask

  task automatic drive_write(input int ch, input int mode, input int rate, input int level);
    cfg_valid = 1'b1;
    cfg_chan  = 4'(ch);
    cfg_mode  = 3'(mode);
    cfg_rate  = RW'(rate);
    cfg_level = PB'(level);
    next_cycle();
    cfg_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    s_reset   = 1'b1;
    cfg_valid = 1'b0;
    repeat (n) begin
      next_cycle();
      check("rst_led", led_out, 0);
      check("rst_ready", cfg_ready, 0);
    end
    s_reset = 1'b0;
    next_cycle();
    check("ready_2nd_cycle", cfg_ready, 1);
  endtask

  // Measures ch0 blink timing after a write just accepted; ticks counted from now.
  task automatic blink_measure(input int rate, input string nm);
    int ticks = 0;
    int t_at  = -1000;
    int rise  = -1;
    int fall  = -1;
    logic prev;
    prev = led_out[0];
    for (int k = 0; (k < 400) && (fall < 0); k++) begin
      if (m_tick) begin
        ticks++;
        if (ticks == rate + 1) t_at = k;
      end
      next_cycle();
      if ((rise < 0) && (prev === 1'b0) && (led_out[0] === 1'b1)) rise = k + 1;
      else if ((rise >= 0) && (fall < 0) && (led_out[0] === 1'b0)) fall = k + 1;
      prev = led_out[0];
    end
    check({nm, "_rise_after_tick"}, rise - t_at, 2);
    check({nm, "_half_period"}, fall - rise, TD * (rate + 1));
  endtask

  initial begin
    int cnt;
    int ticks_seen;
    s_reset = 1'b1; cfg_valid = 1'b0; cfg_chan = 4'd0; cfg_mode = 3'd0;
    cfg_rate = '0; cfg_level = '0;
    for (int ch = 0; ch < NL; ch++) begin
      m_mode[ch] = 0; m_rate[ch] = 0; m_level[ch] = 0; m_n[ch] = 0;
    end

    // Reset and timebase
    do_reset(3);
    ticks_seen = 0;
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      ticks_seen += int'(tick);
    end
    check("ticks_in_16_cycles", ticks_seen, 4);

    // Directed vector table: steady modes, discarded and reserved writes
    vecs[0] = '{4'd2,  3'd1, 4'b0100};
    vecs[1] = '{4'd2,  3'd0, 4'b0000};
    vecs[2] = '{4'd7,  3'd1, 4'b0000};
    vecs[3] = '{4'd1,  3'd1, 4'b0010};
    vecs[4] = '{4'd15, 3'd0, 4'b0010};
    vecs[5] = '{4'd0,  3'd5, 4'b0010};
    vecs[6] = '{4'd3,  3'd1, 4'b1010};
    vecs[7] = '{4'd3,  3'd7, 4'b0010};
    vecs[8] = '{4'd1,  3'd4, 4'b0000};
    for (int i = 0; i < 9; i++) begin
      drive_write(int'(vecs[i].chan), int'(vecs[i].mode), 0, 0);
      check($sformatf("vec%0d_accept_edge", i), led_out, (i == 0) ? 4'b0000 : vecs[i-1].exp_led);
      next_cycle();
      check($sformatf("vec%0d_result", i), led_out, vecs[i].exp_led);
    end

    // BLINK rate 2
    do_reset(2);
    for (int k = 0; (k < 8) && ((m_j % TD) != 0); k++) next_cycle();
    drive_write(0, 2, 2, 0);
    blink_measure(2, "blink_r2");

    // Write coinciding with a tick: that tick must not advance the counter
    drive_write(0, 0, 0, 0);
    repeat (3) next_cycle();
    for (int k = 0; (k < 8) && !m_tick; k++) next_cycle();
    check("tick_found_for_coincide", m_tick, 1);
    drive_write(0, 2, 1, 0);
    blink_measure(1, "coincide");

    // Reset mid-blink with a write pending
    repeat (7) next_cycle();
    s_reset = 1'b1; cfg_valid = 1'b1; cfg_chan = 4'd0; cfg_mode = 3'd1;
    next_cycle();
    check("midrst_led", led_out, 0);
    check("midrst_ready", cfg_ready, 0);
    s_reset = 1'b0; cfg_valid = 1'b0;
    repeat (4) next_cycle();
    check("after_midrst_led", led_out, 0);

    // PWM duty over a full 256-cycle period
    drive_write(1, 3, 0, 64);
    next_cycle();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin next_cycle(); cnt += int'(led_out[1]); end
    check("pwm_64", cnt, 64);
    drive_write(1, 3, 0, 0);
    next_cycle();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin next_cycle(); cnt += int'(led_out[1]); end
    check("pwm_0", cnt, 0);
    drive_write(1, 3, 0, 255);
    next_cycle();
    cnt = 0;
    for (int k = 0; k < 256; k++) begin next_cycle(); cnt += int'(led_out[1]); end
    check("pwm_255", cnt, 255);

    // BREATHE on ch3 at rate 0
    do_reset(2);
    drive_write(3, 4, 0, 0);
    cnt = 0;
    for (int k = 0; k < 2200; k++) begin next_cycle(); cnt += int'(led_out[3]); end
`ifndef LED_BREATHE_EN
    check("breathe_disabled_off", cnt, 0);
`endif

    // Randomized writes and occasional resets, checked by the model each cycle
    do_reset(2);
    for (int k = 0; k < 4000; k++) begin
      s_reset   = ($urandom_range(0, 599) == 0);
      cfg_valid = ($urandom_range(0, 29) == 0);
      cfg_chan  = 4'($urandom_range(0, 7));
      cfg_mode  = 3'($urandom_range(0, 7));
      cfg_rate  = RW'($urandom_range(0, 3));
      cfg_level = PB'($urandom_range(0, 255));
      next_cycle();
    end
    s_reset = 1'b0; cfg_valid = 1'b0;
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Multi-channel LED driver and the parametrised successor to the single-LED heartbeat blinker. It drives NUM_LEDS outputs, and each channel is independently programmable as OFF, ON, BLINK at a programmable rate, or fixed-duty PWM dimming. An optional BREATHE mode can be compiled in. It sits on the board top level between the control/status logic (config writes over a valid/ready port) and the LED pins.

## Interface
- CLK_FREQ_HZ, 100_000_000: clk frequency; documentation only, not used in logic.
- TICK_DIV, 100_000: clk cycles per timebase tick (1 ms at 100 MHz); must be ≥ 2.
- NUM_LEDS, 4: number of channels, 1..16.
- RATE_W, 16: width of per-channel rate field.
- PWM_BITS, 8: PWM resolution.

Ports:
- clk  in  1  system clock.
- s_reset  in  1  reset s_reset, synchronous, active-high; clock clk.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  block can accept a write.
- cfg_chan  in  4  target channel index.
- cfg_mode  in  3  0 OFF, 1 ON, 2 BLINK, 3 PWM, 4 BREATHE; 5-7 reserved.
- cfg_rate  in  RATE_W  tick count for BLINK/BREATHE steps.
- cfg_level  in  PWM_BITS  PWM duty for mode 3.
- tick  out  1  one-cycle timebase strobe, for observation.
- led_out  out  NUM_LEDS  registered LED drive, active-high.

## Operation
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick=1 on the cycle the count equals TICK_DIV-1.
- PWM counter: shared, PWM_BITS wide, increments every clk and wraps freely.
- Write accepted on a clk edge where cfg_valid && cfg_ready.
  - The channel's mode/rate/level registers load on that edge.
  - The channel's tick counter, blink phase, breathe level and breathe direction clear to 0/up on the same edge.
- cfg_chan ≥ NUM_LEDS: write accepted (handshake completes) and discarded; no state changes.
- Reserved modes 5-7 are stored but behave as OFF.
- Per-channel behaviour:
  - OFF: led=0.
  - ON: led=1.
  - BLINK: channel counter advances on tick. When the counter equals cfg_rate on a tick, it wraps to 0 and phase toggles. led=phase. Full period = 2×(rate+1) ticks; rate=0 toggles every tick.
  - PWM: led = (pwm_cnt < level). Level 0 gives a constant 0. Level 2^PWM_BITS-1 is high 255 of 256 cycles (PWM_BITS=8).
  - BREATHE: see Configuration.
- Simultaneous write and tick on the same channel: the write wins, the counter clears, and that tick is ignored for the channel.
- cfg_ready is 1 at all times except during reset and the first cycle after s_reset deasserts.

## Timing
- Reset values:
  - led_out=0, tick=0, cfg_ready=0.
  - All channels: mode OFF, rate 0, level 0, counters 0, phase 0.
  - Prescaler and PWM counter are 0.
- cfg_ready is registered: ready <= ~s_reset, so it rises one cycle after s_reset falls.
- Write latency: a write accepted at edge N changes led_out at edge N+1.
- BLINK: first toggle occurs at the (rate+1)-th tick after the write; led_out changes one cycle after that tick.
- PWM output lags the comparison by one register stage.
- s_reset asserted mid-operation: all state returns to reset values at the next edge, regardless of cfg_valid.

## Configuration
- LED_BREATHE_EN defined:
  - Mode 4 = BREATHE. The channel level steps by ±1 each time the counter reaches rate on a tick.
  - Direction: ramps 0→2^PWM_BITS-1 then down to 0, reversing at each end. The end values are held for exactly one step.
  - led driven by PWM at the current level.
- LED_BREATHE_EN undefined: mode 4 behaves as OFF, and the breathe level and direction registers are not synthesised.

## Structure
- Package led_pattern_pkg holds:
  - mode localparams (MODE_OFF, MODE_ON, MODE_BLINK, MODE_PWM, MODE_BREATHE);
  - CFG_MODE_W=3 and CFG_CHAN_W=4.
- Sub-module led_channel: per-channel config registers, tick counter, phase, breathe state and output register. It is instantiated NUM_LEDS times via generate.
- The top level holds the prescaler, PWM counter, cfg_ready register and address decode.

## Test plan
All scenarios use sim with TICK_DIV=4, NUM_LEDS=4, PWM_BITS=8.
- Reset:
  - Stimulus: hold s_reset 3 cycles, then release.
  - Required: led_out=0 and cfg_ready=0 during reset; cfg_ready=1 on the 2nd cycle after release; tick pulses every 4 cycles.
- ON/OFF:
  - Stimulus: write ch2 mode 1, then write ch2 mode 0.
  - Required: led_out[2] goes 1 one cycle after the first accept and 0 one cycle after the second; other bits stay 0.
- BLINK:
  - Stimulus: write ch0 mode 2, rate 2.
  - Required: led_out[0] toggles every 3 ticks (12 clk); first rise on the cycle after the 3rd tick.
- PWM:
  - Stimulus 1: write ch1 mode 3, level 64. Required: led_out[1] high exactly 64 of every 256 cycles.
  - Stimulus 2: level 0. Required: constant 0.
- Edge cases:
  - Stimulus: write coinciding with tick; write to cfg_chan=7; assert s_reset mid-BLINK.
  - Required: the channel counter restarts from 0; no channel changes for cfg_chan=7; all outputs are 0 next cycle after s_reset.
- BREATHE (LED_BREATHE_EN defined):
  - Stimulus: write ch3 mode 4, rate 0.
  - Required: duty rises 0→255 over 255 ticks, then falls; with the macro undefined, led_out[3] stays 0.
